// File: rtl/spi_dev_regbank_if.sv
// spi_dev_regbank_if: SPI pin bundle between an SPI host and the register-bank target
interface spi_dev_regbank_if;
  logic spi_sck_i;
  logic spi_csb_i;
  logic spi_mosi_i;
  logic spi_miso_o;
  logic spi_miso_en_o;
  modport master (output spi_sck_i, spi_csb_i, spi_mosi_i, input spi_miso_o, spi_miso_en_o);
  modport slave (input spi_sck_i, spi_csb_i, spi_mosi_i, output spi_miso_o, spi_miso_en_o);
endinterface

// File: rtl/spi_dev_regbank.sv
// spi_dev_regbank: SPI mode-0 target giving a host read/write access to 8-bit registers; define SPI_DEV_AUTOINC_EN for burst address auto-increment
module spi_dev_regbank #(
  parameter int NumRegs    = 16,
  parameter int SyncStages = 2
) (
  input  logic                   soc_clk,
  input  logic                   rst_n,
  spi_dev_regbank_if.slave       spi,
  output logic [8*NumRegs-1:0]   regs_o,
  output logic [NumRegs-1:0]     wr_pulse_o,
  output logic                   frame_active_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CMD   = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] READ  = 2'd3;
  logic [SyncStages-1:0] sck_s, csb_s, mosi_s;
  logic sck_d, csb_d, sck_rise, sck_fall, csb_rise, csb_fall, mosi_q, miso_q;
  logic [1:0] state;
  logic [2:0] cnt;
  logic [6:0] addr, next_addr, rx;
  logic [7:0] tx, rx_byte;
  assign rx_byte = {rx, mosi_q};
`ifdef SPI_DEV_AUTOINC_EN
  assign next_addr = (addr == 7'(NumRegs - 1)) ? 7'd0 : addr + 7'd1;
`else
  assign next_addr = addr;
`endif
  assign frame_active_o    = ~csb_s[SyncStages-1];
  assign spi.spi_miso_en_o = state == READ;
  assign spi.spi_miso_o    = (state == READ) & miso_q;
  function automatic logic [7:0] rd(input logic [6:0] a, input logic [8*NumRegs-1:0] r);
    rd = 8'hFF;
    for (int i = 0; i < NumRegs; i++)
      if (a == 7'(i)) rd = r[8*i +: 8];
  endfunction
  // synchronise the SPI pins and register one-cycle edge strobes
  always_ff @(posedge soc_clk or negedge rst_n)
    if (!rst_n) begin
      sck_s    <= '0;
      csb_s    <= '1;
      mosi_s   <= '0;
      sck_d    <= 1'b0;
      csb_d    <= 1'b1;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      csb_rise <= 1'b0;
      csb_fall <= 1'b0;
      mosi_q   <= 1'b0;
    end else begin
      sck_s    <= {sck_s[SyncStages-2:0], spi.spi_sck_i};
      csb_s    <= {csb_s[SyncStages-2:0], spi.spi_csb_i};
      mosi_s   <= {mosi_s[SyncStages-2:0], spi.spi_mosi_i};
      sck_d    <= sck_s[SyncStages-1];
      csb_d    <= csb_s[SyncStages-1];
      sck_rise <= sck_s[SyncStages-1] & ~sck_d;
      sck_fall <= ~sck_s[SyncStages-1] & sck_d;
      csb_rise <= csb_s[SyncStages-1] & ~csb_d;
      csb_fall <= ~csb_s[SyncStages-1] & csb_d;
      mosi_q   <= mosi_s[SyncStages-1];
    end
  // frame FSM: command decode, register writes, read-data shifting
  always_ff @(posedge soc_clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      addr       <= 7'd0;
      rx         <= 7'd0;
      tx         <= 8'd0;
      miso_q     <= 1'b0;
      regs_o     <= '0;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (csb_rise) begin
        state  <= IDLE;
        miso_q <= 1'b0;
      end else begin
        case (state)
          IDLE: if (csb_fall) begin
            state  <= CMD;
            cnt    <= 3'd0;
            miso_q <= 1'b0;
          end
          CMD: if (sck_rise) begin
            rx  <= rx_byte[6:0];
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              addr  <= rx_byte[6:0];
              state <= rx_byte[7] ? READ : WRITE;
              tx    <= rd(rx_byte[6:0], regs_o);
            end
          end
          WRITE: if (sck_rise) begin
            rx  <= rx_byte[6:0];
            cnt <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              addr <= next_addr;
              for (int i = 0; i < NumRegs; i++)
                if (addr == 7'(i)) begin
                  regs_o[8*i +: 8] <= rx_byte;
                  wr_pulse_o[i]    <= 1'b1;
                end
            end
          end
          default: begin
            if (sck_rise) begin
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) begin
                addr <= next_addr;
                tx   <= rd(next_addr, regs_o);
              end
            end
            if (sck_fall) begin
              miso_q <= tx[7];
              tx     <= {tx[6:0], 1'b0};
            end
          end
        endcase
      end
    end
endmodule

// File: tb/tb_spi_dev_regbank.sv
// tb_spi_dev_regbank: scoreboard bench driving SPI frames and checking writes and read-back bytes
module tb_spi_dev_regbank;
  localparam int HALF = 100;
  typedef struct {int idx; logic [7:0] val;} wr_t;
  logic soc_clk = 1'b0;
  logic rst_n = 1'b0;
  logic [127:0] regs;
  logic [15:0] wr_pulse;
  logic frame_active;
  int n_tests = 0;
  int n_fail = 0;
  wr_t exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] mem[16];
  logic [7:0] rbyte = 8'd0;
  int rcnt = 0;
  wr_t e;
  logic [7:0] eb;
  spi_dev_regbank_if tif();
  spi_dev_regbank #(.NumRegs(16), .SyncStages(2)) dut (
    .soc_clk(soc_clk), .rst_n(rst_n), .spi(tif),
    .regs_o(regs), .wr_pulse_o(wr_pulse), .frame_active_o(frame_active));
  always #5 soc_clk = ~soc_clk;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [127:0] model_vec();
    logic [127:0] v;
    for (int i = 0; i < 16; i++) v[8*i +: 8] = mem[i];
    return v;
  endfunction
  task automatic expect_write(input int idx, input logic [7:0] val);
    exp_wr.push_back('{idx, val});
    if (idx < 16) mem[idx] = val;
  endtask
  task automatic bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      tif.spi_mosi_i = b[i];
      #HALF tif.spi_sck_i = 1'b1;
      #HALF tif.spi_sck_i = 1'b0;
    end
  endtask
  task automatic cs_low();
    tif.spi_csb_i = 1'b0;
    #HALF;
  endtask
  task automatic cs_high();
    #HALF tif.spi_csb_i = 1'b1;
    #(4*HALF);
  endtask
  task automatic frame2(input logic [7:0] c, input logic [7:0] d);
    cs_low();
    bits(c, 8);
    bits(d, 8);
    cs_high();
  endtask
  task automatic frame3(input logic [7:0] c, input logic [7:0] d0, input logic [7:0] d1);
    cs_low();
    bits(c, 8);
    bits(d0, 8);
    bits(d1, 8);
    cs_high();
  endtask
  // write monitor: every pulse must match the next expected write
  always @(negedge soc_clk)
    if (rst_n && wr_pulse != 16'd0) begin
      if (exp_wr.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_wr_pulse: got %h expected none", wr_pulse);
      end else begin
        e = exp_wr.pop_front();
        check("wr_pulse", {112'd0, wr_pulse}, {112'd0, 16'd1 << e.idx});
        check("wr_data", {120'd0, regs[8*e.idx +: 8]}, {120'd0, e.val});
      end
    end
  // read monitor: assemble host-side bytes while MISO is enabled
  always @(posedge tif.spi_sck_i)
    if (tif.spi_miso_en_o) begin
      rbyte = {rbyte[6:0], tif.spi_miso_o};
      rcnt++;
      if (rcnt == 8) begin
        rcnt = 0;
        if (exp_rd.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_read: got %h expected none", rbyte);
        end else begin
          eb = exp_rd.pop_front();
          check("rd_data", {120'd0, rbyte}, {120'd0, eb});
        end
      end
    end
  always @(posedge tif.spi_csb_i) rcnt = 0;
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    tif.spi_sck_i = 1'b0;
    tif.spi_csb_i = 1'b1;
    tif.spi_mosi_i = 1'b0;
    #33 rst_n = 1'b1;
    #40;
    check("rst_regs", regs, 128'd0);
    check("rst_miso", {127'd0, tif.spi_miso_o}, 128'd0);
    check("rst_miso_en", {127'd0, tif.spi_miso_en_o}, 128'd0);
    check("rst_wr_pulse", {112'd0, wr_pulse}, 128'd0);
    check("rst_frame_active", {127'd0, frame_active}, 128'd0);
    expect_write(3, 8'hA5);
    frame2(8'h03, 8'hA5);
    check("regs_after_write", regs, model_vec());
    exp_rd.push_back(8'hA5);
    frame2(8'h83, 8'h00);
    check("miso_en_after_read", {127'd0, tif.spi_miso_en_o}, 128'd0);
    frame2(8'h7F, 8'h55);
    check("regs_after_oor_write", regs, model_vec());
    exp_rd.push_back(8'hFF);
    frame2(8'hFF, 8'h00);
    cs_low();
    bits(8'h02, 8);
    bits(8'h99, 5);
    cs_high();
    check("regs_after_abort", regs, model_vec());
    check("abort_idle_en", {127'd0, tif.spi_miso_en_o}, 128'd0);
    check("abort_frame_inactive", {127'd0, frame_active}, 128'd0);
    expect_write(2, 8'h3C);
    frame2(8'h02, 8'h3C);
    check("regs_after_rewrite", regs, model_vec());
    expect_write(15, 8'h11);
`ifdef SPI_DEV_AUTOINC_EN
    expect_write(0, 8'h22);
`else
    expect_write(15, 8'h22);
`endif
    frame3(8'h0F, 8'h11, 8'h22);
    check("regs_after_burst", regs, model_vec());
    exp_rd.push_back(8'hA5);
`ifdef SPI_DEV_AUTOINC_EN
    exp_rd.push_back(8'h00);
`else
    exp_rd.push_back(8'hA5);
`endif
    frame3(8'h83, 8'h00, 8'h00);
    cs_low();
    bits(8'h82, 8);
    bits(8'h00, 3);
    check("miso_en_mid_read", {127'd0, tif.spi_miso_en_o}, 128'd1);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    check("mid_rst_regs", regs, 128'd0);
    check("mid_rst_miso", {127'd0, tif.spi_miso_o}, 128'd0);
    check("mid_rst_miso_en", {127'd0, tif.spi_miso_en_o}, 128'd0);
    check("mid_rst_wr_pulse", {112'd0, wr_pulse}, 128'd0);
    check("mid_rst_frame_active", {127'd0, frame_active}, 128'd0);
    #22 rst_n = 1'b1;
    bits(8'h00, 5);
    check("post_rst_miso_en", {127'd0, tif.spi_miso_en_o}, 128'd0);
    cs_high();
    exp_rd.push_back(8'h00);
    frame2(8'h83, 8'h00);
    check("regs_final", regs, model_vec());
    #(4*HALF);
    check("wr_queue_drained", 128'(exp_wr.size()), 128'd0);
    check("rd_queue_drained", 128'(exp_rd.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
